fire_cmd_scheduler: RTL

FIRE_CMD_SCHEDULER -- requirements
Module: fire_cmd_scheduler

---
 rtl/lvds_pkg.sv | 32 +++
 rtl/cmd_fifo.sv | 62 ++++++
 rtl/fire_cmd_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lvds_pkg.sv
// Shared command codes and scheduler state encoding for the
// fire command path.
package lvds_pkg;

    localparam logic [3:0] CMD_PREFILL       = 4'hA;
    localparam logic [3:0] CMD_UP            = 4'h1;
    localparam logic [3:0] CMD_DOWN          = 4'h2;
    localparam logic [3:0] CMD_SHAKE_UP      = 4'h3;
    localparam logic [3:0] CMD_PRINT         = 4'h4;
    localparam logic [3:0] CMD_SHAKE_DOWN    = 4'h5;
    localparam logic [3:0] CMD_SHAKE_BEFORE  = 4'h6;
    localparam logic [3:0] CMD_SHAKE_BETWEEN = 4'h9;
    localparam logic [3:0] CMD_PASS_END      = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_INT
    } sched_state_t;

    function automatic logic is_valid_cmd(logic [3:0] c);
        case (c)
            CMD_PREFILL, CMD_UP, CMD_DOWN,
            CMD_SHAKE_UP, CMD_PRINT, CMD_SHAKE_DOWN,
            CMD_SHAKE_BEFORE, CMD_SHAKE_BETWEEN,
            CMD_PASS_END: is_valid_cmd = 1'b1;
            default:      is_valid_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue; a pop frees a slot for a push
// in the same cycle even when full.
module cmd_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            ptr_next = '0;
        else
            ptr_next = p + 1'b1;
    endfunction

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fire_cmd_scheduler.sv
// Turns mainboard FIRE events into paced waveform launches and
// the pass-end interrupt.
module fire_cmd_scheduler
    import lvds_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 200,
    parameter int TIMEOUT    = 50000,
    parameter int INT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       fire_in,
    input  logic [3:0] f_cmd,
    input  logic       wave_done,
    input  logic       sticky_clr,
    output logic       wave_start,
    output logic [3:0] wave_cmd,
    output logic       fpga_int1,
    output logic [2:0] q_level,
    output logic       err_overrun,
    output logic       err_badcmd,
    output logic       err_timeout
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);

    sched_state_t state;
    logic [15:0]  cnt;
    logic         pend_end;

    logic         fire_s1, fire_s2, fire_s3;
    logic [3:0]   cmd_s1, cmd_s2;

    logic         fire_evt;
    logic         end_evt;
    logic         bad_evt;
    logic         ovr_evt;
    logic         tmo_evt;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [3:0]   head;
    logic [LW-1:0] level;

    // fire_s3 only delays the synchronised level for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire_s1 <= 1'b0;
            fire_s2 <= 1'b0;
            fire_s3 <= 1'b0;
            cmd_s1  <= '0;
            cmd_s2  <= '0;
        end else begin
            fire_s1 <= fire_in;
            fire_s2 <= fire_s1;
            fire_s3 <= fire_s2;
            cmd_s1  <= f_cmd;
            cmd_s2  <= cmd_s1;
        end
    end

    assign fire_evt = fire_s2 && !fire_s3;
    assign end_evt  = fire_evt && (cmd_s2 == CMD_PASS_END);
    assign bad_evt  = fire_evt && !is_valid_cmd(cmd_s2);
    assign push     = fire_evt && is_valid_cmd(cmd_s2) && !end_evt;
    assign pop      = (state == S_IDLE) && !empty;
    assign ovr_evt  = push && full && !pop;
    assign tmo_evt  = (state == S_RUN) && !wave_done
                   && (cnt == 16'(TIMEOUT - 1));
    assign q_level  = 3'(level);

    cmd_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (cmd_s2),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wave_start <= 1'b0;
            wave_cmd   <= '0;
            fpga_int1  <= 1'b1;
            pend_end   <= 1'b0;
        end else begin
            wave_start <= 1'b0;
            // repeated pass-end requests collapse into one interrupt
            if (end_evt && state != S_INT)
                pend_end <= 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!empty) begin
                        wave_start <= 1'b1;
                        wave_cmd   <= head;
                        state      <= S_RUN;
                    end else if (pend_end) begin
                        pend_end  <= 1'b0;
                        fpga_int1 <= 1'b0;
                        state     <= S_INT;
                    end
                end
                S_RUN: begin
                    if (wave_done || tmo_evt) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'(MIN_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INT: begin
                    if (cnt == 16'(INT_CYCLES - 1)) begin
                        cnt       <= '0;
                        fpga_int1 <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // a set event in the clear cycle keeps the flag up
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_overrun <= 1'b0;
            err_badcmd  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (ovr_evt)
                err_overrun <= 1'b1;
            else if (sticky_clr)
                err_overrun <= 1'b0;
            if (bad_evt)
                err_badcmd <= 1'b1;
            else if (sticky_clr)
                err_badcmd <= 1'b0;
            if (tmo_evt)
                err_timeout <= 1'b1;
            else if (sticky_clr)
                err_timeout <= 1'b0;
        end
    end

endmodule
